// File: rtl/gen_tile_coord_pkg.sv
// Shared tiling arithmetic for the tiled convolution engine: ceiling
// division plus the step/limit/tile-count derivations that the tile
// sequencer, conv_tile and the top level all compute from the layer shape.
package gen_tile_coord_pkg;

  // Integer ceiling division for positive operands.
  function automatic int ceil_div(input int x, input int y);
    return (x + y - 1) / y;
  endfunction

  // Distance between consecutive tile bases along one spatial axis.
  // Adjacent input-side tiles overlap by K-S pixels.
  function automatic int tile_step(input int t, input int k, input int s);
    return t - k + s;
  endfunction

  // Last usable input coordinate along an axis, rounded to the stride grid.
  function automatic int tile_lim(input int d, input int k, input int s);
    return ((d + s - k) / s) * s;
  endfunction

  // Total number of tiles in one layer pass.
  function automatic int tile_count(input int n, input int tn,
                                    input int m, input int tm,
                                    input int r, input int tr,
                                    input int c, input int tc,
                                    input int k, input int s);
    return ceil_div(n, tn) * ceil_div(m, tm) *
           ceil_div(tile_lim(r, k, s), tile_step(tr, k, s)) *
           ceil_div(tile_lim(c, k, s), tile_step(tc, k, s));
  endfunction

  // Values for the default layer shape.
  localparam int DEF_ROW_STEP = tile_step(16, 3, 1);
  localparam int DEF_COL_STEP = tile_step(10, 3, 1);
  localparam int DEF_ROW_LIM  = tile_lim(32, 3, 1);
  localparam int DEF_COL_LIM  = tile_lim(16, 3, 1);
  localparam int DEF_TILE_NUM = tile_count(16, 8, 16, 8, 32, 16, 16, 10, 3, 1);

endpackage

// File: rtl/gen_tile_coord_wrap.sv
// One wrapping coordinate register: adds STEP on inc, returns to zero and
// raises carry when the sum would reach LIMIT. The sum is one bit wider
// than the register so large steps cannot alias past the limit.
module wrap_step_cnt
  import gen_tile_coord_pkg::*;
#(
  parameter int CW    = 16,
  parameter int STEP  = 1,
  parameter int LIMIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clean,
  output logic [CW-1:0] value,
  output logic          carry
);

  localparam int        SW      = CW + 1;
  localparam logic [CW:0] STEP_W  = SW'(STEP);
  localparam logic [CW:0] LIMIT_W = SW'(LIMIT);

  logic [CW-1:0] value_reg;
  logic [CW-1:0] value_next;
  logic [CW:0]   sum;

  assign sum   = {1'b0, value_reg} + STEP_W;
  assign carry = inc && (sum >= LIMIT_W);
  assign value = value_reg;

  // Next value: clear wins, otherwise step with wrap on carry.
  always_comb begin
    value_next = value_reg;
    if (clean) begin
      value_next = '0;
    end else if (inc) begin
      value_next = carry ? '0 : sum[CW-1:0];
    end
  end

  // Coordinate register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

endmodule

// File: rtl/gen_tile_coord.sv
// Tile sequencer: walks tile bases in the order m (innermost), n, col, row,
// counts finished tiles and pulses conv_done once the layer is complete.
module gen_tile_coord
  import gen_tile_coord_pkg::*;
#(
  parameter int CW = 16,
  parameter int N  = 16,
  parameter int M  = 16,
  parameter int R  = 32,
  parameter int C  = 16,
  parameter int K  = 3,
  parameter int S  = 1,
  parameter int Tn = 8,
  parameter int Tm = 8,
  parameter int Tr = 16,
  parameter int Tc = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          conv_tile_done,
  input  logic          clean,
  output logic [CW-1:0] tile_base_n,
  output logic [CW-1:0] tile_base_m,
  output logic [CW-1:0] tile_base_row,
  output logic [CW-1:0] tile_base_col,
  output logic [CW-1:0] tile_idx,
  output logic          last_tile,
  output logic          conv_done
);

  localparam int ROW_STEP = tile_step(Tr, K, S);
  localparam int COL_STEP = tile_step(Tc, K, S);
  localparam int ROW_LIM  = tile_lim(R, K, S);
  localparam int COL_LIM  = tile_lim(C, K, S);
  localparam int TILE_NUM = tile_count(N, Tn, M, Tm, R, Tr, C, Tc, K, S);

  // Axis order in the chain: 0=m, 1=n, 2=col, 3=row.
  logic [3:0]    inc_vec;
  logic [3:0]    carry_vec;
  logic [CW-1:0] base_vec [4];
  logic          tile_carry;
  logic          layer_end;
  logic          coord_clr;
  logic          conv_done_reg;

  assign inc_vec = {carry_vec[2:0], conv_tile_done};

  // The layer ends when either the tile count or the outermost axis wraps;
  // with a consistent shape both happen on the same pulse.
  assign layer_end = !clean && (tile_carry || carry_vec[3]);
  assign coord_clr = clean || layer_end;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_axis
      localparam int STEP_G  = (gi == 0) ? Tm : (gi == 1) ? Tn :
                               (gi == 2) ? COL_STEP : ROW_STEP;
      localparam int LIMIT_G = (gi == 0) ? M : (gi == 1) ? N :
                               (gi == 2) ? COL_LIM : ROW_LIM;
      wrap_step_cnt #(
        .CW   (CW),
        .STEP (STEP_G),
        .LIMIT(LIMIT_G)
      ) u_axis (
        .clk  (clk),
        .rst  (rst),
        .inc  (inc_vec[gi]),
        .clean(coord_clr),
        .value(base_vec[gi]),
        .carry(carry_vec[gi])
      );
    end
  endgenerate

  wrap_step_cnt #(
    .CW   (CW),
    .STEP (1),
    .LIMIT(TILE_NUM)
  ) u_tile_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (conv_tile_done),
    .clean(coord_clr),
    .value(tile_idx),
    .carry(tile_carry)
  );

  // One-cycle completion pulse registered from the final tile's done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conv_done_reg <= 1'b0;
    end else begin
      conv_done_reg <= layer_end;
    end
  end

  assign tile_base_m   = base_vec[0];
  assign tile_base_n   = base_vec[1];
  assign tile_base_col = base_vec[2];
  assign tile_base_row = base_vec[3];
  assign last_tile     = (tile_idx == CW'(TILE_NUM - 1));
  assign conv_done     = conv_done_reg;

endmodule

// File: tb/tb_gen_tile_coord.sv
// Bench for gen_tile_coord: directed scenarios plus random done/clean
// traffic, checked against a tile-index model that derives every base by
// mixed-radix decomposition of the completed-tile count.
module tb_gen_tile_coord;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        conv_tile_done = 1'b0;
  logic        clean = 1'b0;
  logic [15:0] tile_base_n, tile_base_m, tile_base_row, tile_base_col, tile_idx;
  logic        last_tile, conv_done;

  int errors = 0;
  int checks = 0;

  // Reference state: tiles completed so far and whether the layer just ended.
  int t_m    = 0;
  bit done_m = 1'b0;

  gen_tile_coord dut (
    .clk           (clk),
    .rst           (rst),
    .conv_tile_done(conv_tile_done),
    .clean         (clean),
    .tile_base_n   (tile_base_n),
    .tile_base_m   (tile_base_m),
    .tile_base_row (tile_base_row),
    .tile_base_col (tile_base_col),
    .tile_idx      (tile_idx),
    .last_tile     (last_tile),
    .conv_done     (conv_done)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {n, m, row, col, idx, last, done}.
  // Default shape: 2 m-tiles, 2 n-tiles, 2 col-tiles, 3 row-tiles = 24.
  function automatic logic [81:0] model_vec();
    int m, n, col, row;
    m   = (t_m % 2) * 8;
    n   = ((t_m / 2) % 2) * 8;
    col = ((t_m / 4) % 2) * 8;
    row = (t_m / 8) * 14;
    return {16'(n), 16'(m), 16'(row), 16'(col), 16'(t_m),
            (t_m == 23), done_m};
  endfunction

  function automatic logic [81:0] dut_vec();
    return {tile_base_n, tile_base_m, tile_base_row, tile_base_col,
            tile_idx, last_tile, conv_done};
  endfunction

  // Apply inputs for one clock edge, then advance the model. Called at
  // posedge+1 so the inputs are stable well before the next edge.
  task automatic cycle(input bit d, input bit c);
    conv_tile_done = d;
    clean          = c;
    @(posedge clk);
    #1;
    conv_tile_done = 1'b0;
    clean          = 1'b0;
    if (c) begin
      t_m = 0; done_m = 1'b0;
    end else if (d) begin
      if (t_m == 23) begin t_m = 0; done_m = 1'b1; end
      else begin t_m = t_m + 1; done_m = 1'b0; end
    end else begin
      done_m = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 82'd0) begin
      errors++;
      $display("FAIL reset_hold got=%h want=%h", dut_vec(), 82'd0);
    end
    rst = 1'b1;
    t_m = 0; done_m = 1'b0;
    cycle(1'b0, 1'b0);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", dut_vec(), model_vec());
    end
    $display("test_reset done t=%0d", t_m);
  endtask

  task automatic test_first_pulses();
    cycle(1'b1, 1'b0);
    checks++;
    if (tile_base_m !== 16'd8 || tile_base_n !== 16'd0 || tile_idx !== 16'd1) begin
      errors++;
      $display("FAIL pulse1 got m=%0d n=%0d idx=%0d want m=8 n=0 idx=1",
               tile_base_m, tile_base_n, tile_idx);
    end
    cycle(1'b1, 1'b0);
    checks++;
    if (tile_base_m !== 16'd0 || tile_base_n !== 16'd8) begin
      errors++;
      $display("FAIL pulse2 got m=%0d n=%0d want m=0 n=8", tile_base_m, tile_base_n);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL pulse_t%0d got=%h want=%h", t_m, dut_vec(), model_vec());
      end
    end
    $display("test_first_pulses done t=%0d", t_m);
  endtask

  // Held conv_tile_done advances one tile per cycle.
  task automatic test_back_to_back();
    while (t_m < 12) begin
      cycle(1'b1, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL b2b_t%0d got=%h want=%h", t_m, dut_vec(), model_vec());
      end
    end
    checks++;
    if (tile_base_row !== 16'd14 || tile_idx !== 16'd12) begin
      errors++;
      $display("FAIL b2b_row got row=%0d idx=%0d want row=14 idx=12",
               tile_base_row, tile_idx);
    end
    $display("test_back_to_back done t=%0d", t_m);
  endtask

  task automatic test_last_and_wrap();
    while (t_m < 23) cycle(1'b1, 1'b0);
    checks++;
    if (tile_base_row !== 16'd28 || tile_base_col !== 16'd8 ||
        tile_base_n !== 16'd8 || tile_base_m !== 16'd8 || last_tile !== 1'b1) begin
      errors++;
      $display("FAIL last_tile got=%h want row=28 col=8 n=8 m=8 last=1", dut_vec());
    end
    cycle(1'b1, 1'b0);
    checks++;
    if (dut_vec() !== 82'd1) begin
      errors++;
      $display("FAIL wrap_done got=%h want=%h", dut_vec(), 82'd1);
    end
    cycle(1'b0, 1'b0);
    checks++;
    if (conv_done !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL done_one_cycle got=%h want=%h", dut_vec(), model_vec());
    end
    $display("test_last_and_wrap done t=%0d", t_m);
  endtask

  task automatic test_clean();
    repeat (5) cycle(1'b1, 1'b0);
    checks++;
    if (tile_idx !== 16'd5) begin
      errors++;
      $display("FAIL clean_pre got idx=%0d want 5", tile_idx);
    end
    cycle(1'b1, 1'b1);
    checks++;
    if (dut_vec() !== 82'd0) begin
      errors++;
      $display("FAIL clean_prio got=%h want=%h", dut_vec(), 82'd0);
    end
    $display("test_clean done t=%0d", t_m);
  endtask

  task automatic test_async_reset();
    repeat (7) cycle(1'b1, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 82'd0) begin
      errors++;
      $display("FAIL async_reset got=%h want=%h", dut_vec(), 82'd0);
    end
    #1;
    rst = 1'b1;
    t_m = 0; done_m = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL async_release got=%h want=%h", dut_vec(), model_vec());
    end
    $display("test_async_reset done t=%0d", t_m);
  endtask

  task automatic test_random();
    bit d, c;
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 59) == 0);
      cycle(d, c);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random_%0d d=%0d c=%0d got=%h want=%h",
                 i, d, c, dut_vec(), model_vec());
      end
    end
    $display("test_random done t=%0d", t_m);
  endtask

  initial begin
    test_reset();
    test_first_pulses();
    test_back_to_back();
    test_last_and_wrap();
    test_clean();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
